clk_div_bank: RTL and testbench

//  Multi-channel fabric clock-enable generator fed by the rPLL output clock. Derives CHANNELS

---
 rtl/clk_div_bank_pkg.sv | 36 +++
 rtl/clk_div_channel.sv | 166 ++++++++++++++++
 rtl/clk_div_bank.sv | 111 +++++++++++
 tb/tb_clk_div_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_bank_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_bank_pkg
// Shared definitions for the clock-enable divider bank: default parameter
// values, divisor encodings for the off/bypass modes, the channel mode type and
// small width helpers used to size selector and counter fields.
// -----------------------------------------------------------------------------
package clk_div_bank_pkg;

    // Default build parameters
    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_DIV_W       = 16;
    localparam int DEF_DIV_VAL     = 27;
    localparam int DEF_LOCK_CYCLES = 255;

    // Divisor encodings with special meaning
    localparam int DIV_OFF    = 0;   // channel disabled, outputs held low
    localparam int DIV_BYPASS = 1;   // outputs held high every cycle

    // Operating mode of a channel, derived from its active divisor
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_DIVIDE = 2'd2
    } div_mode_e;

    // Width of a selector able to address n entries (never below 1 bit)
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n
    function automatic int count_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: period position counter, active and shadow divisor /
// high-time registers, apply logic and registered clk_en / clk_sq / pending.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   wr       in   accepted configuration write for this channel
//   wr_div   in   divisor carried by the write
//   wr_high  in   square-wave high time carried by the write
//   sync     in   restart the period in the next cycle, apply any shadow
//   clk_en   out  one-cycle strobe on the last cycle of each period
//   clk_sq   out  square wave, high for the first high_r cycles of a period
//   pending  out  shadow holds a write that has not yet taken effect
//   apply    out  new configuration takes effect at this clock edge
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_div_bank_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
    input  logic             sync,
    output logic             clk_en,
    output logic             clk_sq,
    output logic             pending,
    output logic             apply
);

    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEF_DIV / 2);
    localparam logic [DIV_W-1:0] ZERO     = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] V_OFF    = DIV_W'(DIV_OFF);
    localparam logic [DIV_W-1:0] V_BYPASS = DIV_W'(DIV_BYPASS);

    // pos_r is the period position that the next clock edge will present on
    // the outputs; zero there means the next cycle opens a new period.
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] high_r;
    logic [DIV_W-1:0] pos_r;
    logic [DIV_W-1:0] sh_div_r;
    logic [DIV_W-1:0] sh_high_r;
    logic             pending_r;
    logic             clk_en_r;
    logic             clk_sq_r;

    logic             start_s;
    logic             direct_s;
    logic             shadow_apply_s;
    logic [DIV_W-1:0] nxt_div_s;
    logic [DIV_W-1:0] nxt_high_s;
    logic [DIV_W-1:0] q_s;
    logic             last_s;
    div_mode_e        mode_s;
    logic             en_s;
    logic             sq_s;
    logic [DIV_W-1:0] pos_nxt_s;
    logic             pend_nxt_s;

    // Decide which configuration governs the next cycle and what it emits
    always_comb begin
        start_s = sync || (pos_r == ZERO);
        // A write lands directly when the next cycle starts a period anyway,
        // or when it switches the channel off (no need to wait for a boundary).
        direct_s       = wr && (start_s || (wr_div == V_OFF));
        shadow_apply_s = pending_r && start_s && !direct_s;

        if (direct_s) begin
            nxt_div_s  = wr_div;
            nxt_high_s = wr_high;
        end else if (shadow_apply_s) begin
            nxt_div_s  = sh_div_r;
            nxt_high_s = sh_high_r;
        end else begin
            nxt_div_s  = div_r;
            nxt_high_s = high_r;
        end

        q_s = start_s ? ZERO : pos_r;

        if (nxt_div_s == V_OFF) begin
            mode_s = MODE_OFF;
        end else if (nxt_div_s == V_BYPASS) begin
            mode_s = MODE_BYPASS;
        end else begin
            mode_s = MODE_DIVIDE;
        end

        // q_s < nxt_div_s always holds, so div-1 never underflows in divide mode
        last_s = (q_s == (nxt_div_s - ONE));

        case (mode_s)
            MODE_OFF: begin
                en_s      = 1'b0;
                sq_s      = 1'b0;
                pos_nxt_s = ZERO;
            end
            MODE_BYPASS: begin
                en_s      = 1'b1;
                sq_s      = 1'b1;
                pos_nxt_s = ZERO;
            end
            MODE_DIVIDE: begin
                en_s      = last_s;
                // high >= div keeps the wave high for the whole period
                sq_s      = (q_s < nxt_high_s);
                pos_nxt_s = last_s ? ZERO : (q_s + ONE);
            end
            default: begin
                en_s      = 1'b0;
                sq_s      = 1'b0;
                pos_nxt_s = ZERO;
            end
        endcase

        if (wr && !direct_s) begin
            pend_nxt_s = 1'b1;
        end else if (shadow_apply_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pending_r;
        end
    end

    // Channel state, shadow capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r     <= RST_DIV;
            high_r    <= RST_HIGH;
            pos_r     <= ZERO;
            sh_div_r  <= RST_DIV;
            sh_high_r <= RST_HIGH;
            pending_r <= 1'b0;
            clk_en_r  <= 1'b0;
            clk_sq_r  <= 1'b0;
        end else begin
            div_r     <= nxt_div_s;
            high_r    <= nxt_high_s;
            pos_r     <= pos_nxt_s;
            pending_r <= pend_nxt_s;
            clk_en_r  <= en_s;
            clk_sq_r  <= sq_s;
            if (wr && !direct_s) begin
                sh_div_r  <= wr_div;
                sh_high_r <= wr_high;
            end else begin
                sh_div_r  <= sh_div_r;
                sh_high_r <= sh_high_r;
            end
        end
    end

    assign clk_en  = clk_en_r;
    assign clk_sq  = clk_sq_r;
    assign pending = pending_r;
    // Internal notification for the lock counter in the parent
    assign apply   = !reset && (direct_s || shadow_apply_s);

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Multi-channel clock-enable generator. Decodes configuration writes onto
// per-channel dividers, exposes per-channel back-pressure through cfg_ready and
// reports lock once every channel has been left untouched for LOCK_CYCLES.
//
// Ports
//   clkin      in   system clock
//   reset      in   synchronous active-high reset
//   cfg_valid  in   configuration write request
//   cfg_ready  out  write accepted when cfg_valid && cfg_ready
//   cfg_ch     in   target channel; out-of-range writes are accepted and dropped
//   cfg_div    in   new divisor (0 = off, 1 = bypass)
//   cfg_high   in   new square-wave high time in cycles
//   sync       in   restart every channel in phase in the next cycle
//   clk_en     out  per-channel end-of-period strobe
//   clk_sq     out  per-channel square wave
//   pending    out  per-channel accepted but not yet applied configuration
//   lock       out  no apply/sync/reset for LOCK_CYCLES cycles
// -----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEF_DIV     = DEF_DIV_VAL,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                           clkin,
    input  logic                           reset,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [sel_width(CHANNELS)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]               cfg_div,
    input  logic [DIV_W-1:0]               cfg_high,
    input  logic                           sync,
    output logic [CHANNELS-1:0]            clk_en,
    output logic [CHANNELS-1:0]            clk_sq,
    output logic [CHANNELS-1:0]            pending,
    output logic                           lock
);

    localparam int CH_W   = sel_width(CHANNELS);
    localparam int LOCK_W = count_width(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

    logic                sel_pending_s;
    logic                cfg_ready_s;
    logic [CHANNELS-1:0] wr_s;
    logic [CHANNELS-1:0] apply_s;
    logic                restart_s;
    logic [LOCK_W-1:0]   lock_cnt_r;
    logic                lock_r;

    // Back-pressure: stall only a valid channel that still holds a shadow write
    always_comb begin
        sel_pending_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_pending_s = sel_pending_s | (pending[i] & (cfg_ch == CH_W'(i)));
        end
        cfg_ready_s = !reset && !sel_pending_s;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_s[i] = cfg_valid && cfg_ready_s && (cfg_ch == CH_W'(i));
        end
        restart_s = sync || (|apply_s);
    end

    assign cfg_ready = cfg_ready_s;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            clk_div_channel #(
                .DIV_W   (DIV_W),
                .DEF_DIV (DEF_DIV)
            ) u_ch (
                .clk     (clkin),
                .reset   (reset),
                .wr      (wr_s[g]),
                .wr_div  (cfg_div),
                .wr_high (cfg_high),
                .sync    (sync),
                .clk_en  (clk_en[g]),
                .clk_sq  (clk_sq[g]),
                .pending (pending[g]),
                .apply   (apply_s[g])
            );
        end
    endgenerate

    // Lock counter: restarts on any reconfiguration, saturates at LOCK_MAX
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_cnt_r <= {LOCK_W{1'b0}};
            lock_r     <= 1'b0;
        end else if (restart_s) begin
            lock_cnt_r <= {LOCK_W{1'b0}};
            lock_r     <= 1'b0;
        end else if (lock_cnt_r == LOCK_MAX) begin
            lock_cnt_r <= lock_cnt_r;
            lock_r     <= 1'b1;
        end else begin
            lock_cnt_r <= lock_cnt_r + LOCK_ONE;
            lock_r     <= ((lock_cnt_r + LOCK_ONE) == LOCK_MAX);
        end
    end

    assign lock = lock_r;

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Self-checking bench for clk_div_bank with three channels. A reference model
// tracks each channel by the absolute cycle at which its current period began;
// expected outputs for the next cycle are queued when stimulus is driven and
// compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int CH    = 3;
    localparam int DW    = 16;
    localparam int DDIV  = 27;
    localparam int LOCKC = 255;
    localparam int CW    = 2;
    localparam int EW    = 3 * CH + 1;

    logic          clkin = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_div;
    logic [DW-1:0] cfg_high;
    logic          sync;
    logic [CH-1:0] clk_en;
    logic [CH-1:0] clk_sq;
    logic [CH-1:0] pending;
    logic          lock;

    always #5 clkin = ~clkin;

    clk_div_bank #(
        .CHANNELS    (CH),
        .DIV_W       (DW),
        .DEF_DIV     (DDIV),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .sync      (sync),
        .clk_en    (clk_en),
        .clk_sq    (clk_sq),
        .pending   (pending),
        .lock      (lock)
    );

    typedef struct {
        int ch;
        int d;
        int h;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    wr_t           wq[$];
    logic [EW-1:0] sbq[$];

    int m_div[CH];
    int m_high[CH];
    int m_start[CH];
    int m_shd[CH];
    int m_shh[CH];
    bit m_shv[CH];
    int m_lcnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < CH; i++) begin
            m_div[i]   = DDIV;
            m_high[i]  = DDIV / 2;
            m_start[i] = 1;
            m_shv[i]   = 1'b0;
            m_shd[i]   = 0;
            m_shh[i]   = 0;
        end
        m_lcnt = 0;
    endfunction

    function automatic logic [EW-1:0] model_expect(input int c);
        logic [CH-1:0] en;
        logic [CH-1:0] sq;
        logic [CH-1:0] pd;
        int            k;
        for (int i = 0; i < CH; i++) begin
            en[i] = 1'b0;
            sq[i] = 1'b0;
            pd[i] = m_shv[i];
            if (m_div[i] == 1) begin
                en[i] = 1'b1;
                sq[i] = 1'b1;
            end else if (m_div[i] >= 2) begin
                k     = (c - m_start[i]) % m_div[i];
                en[i] = (k == m_div[i] - 1);
                sq[i] = (k < m_high[i]);
            end
        end
        return {(m_lcnt == LOCKC), pd, sq, en};
    endfunction

    function automatic bit model_ready(input int ch);
        return (ch >= CH) || !m_shv[ch];
    endfunction

    // Advance the model from cycle c (inputs present) to cycle c+1
    task automatic model_step(input int c, input bit v, input wr_t w, input bit s, output bit acc);
        bit restart;
        bit bnd;
        restart = s;
        acc     = v && model_ready(w.ch);
        for (int i = 0; i < CH; i++) begin
            bnd = (m_div[i] < 2) || (((c + 1 - m_start[i]) % m_div[i]) == 0);
            if (acc && w.ch == i && (s || bnd || w.d == 0)) begin
                m_div[i]   = w.d;
                m_high[i]  = w.h;
                m_start[i] = c + 1;
                restart    = 1'b1;
            end else if (acc && w.ch == i) begin
                m_shv[i] = 1'b1;
                m_shd[i] = w.d;
                m_shh[i] = w.h;
                if (s) m_start[i] = c + 1;
            end else if (m_shv[i] && (s || bnd)) begin
                m_div[i]   = m_shd[i];
                m_high[i]  = m_shh[i];
                m_shv[i]   = 1'b0;
                m_start[i] = c + 1;
                restart    = 1'b1;
            end else if (s) begin
                m_start[i] = c + 1;
            end
        end
        if (restart) m_lcnt = 0;
        else if (m_lcnt < LOCKC) m_lcnt = m_lcnt + 1;
    endtask

    task automatic schedule(input int ph, input int c, output bit s);
        s = 1'b0;
        if (ph == 0) begin
            case (c)
                40:      s = 1'b1;
                60:      wq.push_back('{ch: 1, d: 4, h: 1});
                61:      wq.push_back('{ch: 1, d: 5, h: 2});
                94:      wq.push_back('{ch: 0, d: 9, h: 4});
                100:     wq.push_back('{ch: 2, d: 0, h: 3});
                110:     wq.push_back('{ch: 2, d: 1, h: 0});
                120:     wq.push_back('{ch: 3, d: 7, h: 3});
                380:     wq.push_back('{ch: 3, d: 9, h: 1});
                400:     s = 1'b1;
                420:     wq.push_back('{ch: 0, d: 3, h: 5});
                427:     wq.push_back('{ch: 1, d: 6, h: 3});
                default: s = 1'b0;
            endcase
        end else begin
            case (c)
                300:     s = 1'b1;
                default: s = 1'b0;
            endcase
        end
    endtask

    task automatic run(input int ph, input int n);
        for (int c = 0; c < n; c++) begin
            bit            s;
            bit            acc;
            bit            v;
            bit            exp_rdy;
            wr_t           w;
            logic [EW-1:0] e;
            @(negedge clkin);
            if (c == 0) begin
                reset = 1'b0;
                model_init();
            end
            cyc = c;
            schedule(ph, c, s);
            v = (wq.size() > 0);
            w = '{ch: 0, d: 0, h: 0};
            if (v) w = wq[0];
            cfg_valid = v;
            cfg_ch    = CW'(w.ch);
            cfg_div   = DW'(w.d);
            cfg_high  = DW'(w.h);
            sync      = s;
            #1;
            exp_rdy = model_ready(w.ch);
            if (v) check_val("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
            model_step(c, v, w, s, acc);
            if (acc) void'(wq.pop_front());
            sbq.push_back(model_expect(c + 1));
            @(posedge clkin);
            #1;
            cyc = c + 1;
            e   = sbq.pop_front();
            check_val("clk_en",  32'(clk_en),  32'(e[CH-1:0]));
            check_val("clk_sq",  32'(clk_sq),  32'(e[2*CH-1:CH]));
            check_val("pending", 32'(pending), 32'(e[3*CH-1:2*CH]));
            check_val("lock",    32'(lock),    32'(e[3*CH]));
        end
        cfg_valid = 1'b0;
        sync      = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd0;
        cfg_high  = 16'd0;
        sync      = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        check_val("rst_en",    32'(clk_en),    32'd0);
        check_val("rst_sq",    32'(clk_sq),    32'd0);
        check_val("rst_pend",  32'(pending),   32'd0);
        check_val("rst_lock",  32'(lock),      32'd0);
        check_val("rst_ready", 32'(cfg_ready), 32'd0);

        run(0, 429);

        // One-cycle reset while a shadow write is still waiting
        @(negedge clkin);
        reset     = 1'b1;
        cfg_valid = 1'b0;
        sync      = 1'b0;
        cfg_ch    = 2'd1;
        #1;
        check_val("mid_rst_ready", 32'(cfg_ready), 32'd0);
        @(posedge clkin);
        #1;
        check_val("mid_rst_en",   32'(clk_en),  32'd0);
        check_val("mid_rst_sq",   32'(clk_sq),  32'd0);
        check_val("mid_rst_pend", 32'(pending), 32'd0);
        check_val("mid_rst_lock", 32'(lock),    32'd0);
        wq.delete();
        sbq.delete();

        run(1, 320);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
